hog_cell_feeder: RTL and testbench

- Producer end of the cell-fetch interface consumed by hog_fetch (ready / request / cell data bus).
- Accepts one pixel per cycle from the upstream cell-extraction logic.
- Packs each bordered cell (CELL_S x CELL_S minus the 4 corners) into an IN_W-wide word.
- Queues complete cells in a small FIFO and presents them to hog_fetch on request.

---
 rtl/hog_cell_feeder.sv | 157 +++++++++++++++
 tb/tb_hog_cell_feeder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hog_cell_feeder.sv
// hog_cell_feeder: packs bordered HOG cells from a pixel stream and queues
// them in a small first-word-fall-through FIFO for hog_fetch.
// Optional build macro FEEDER_STAT_EN adds cell_in_cnt / cell_out_cnt.
module hog_cell_feeder #(
  parameter  int unsigned PIX_W  = 8,
  parameter  int unsigned CELL_S = 10,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned CNT_W  = 7,
  localparam int unsigned PIX_N  = CELL_S * CELL_S - 4,
  localparam int unsigned IN_W   = PIX_W * PIX_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             pix_first,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             ready,
  input  logic             request,
  output logic [IN_W-1:0]  o_data,
  output logic             proto_err
`ifdef FEEDER_STAT_EN
  ,
  output logic [15:0]      cell_in_cnt,
  output logic [15:0]      cell_out_cnt
`endif
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_FW = $clog2(DEPTH + 1);

  // Packer state
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [IN_W-1:0]   stage_q, stage_d;
  logic              pix_ready_q, pix_ready_d;
  logic              err_pix;

  // FIFO state
  logic [IN_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              ready_q, ready_d;
  logic [IN_W-1:0]   o_data_q, o_data_d;
  logic              err_q, err_d;
  logic              err_req;

  logic              accept;
  logic              push;
  logic              pop;

  // Packer: place accepted pixels, resync on pix_first, emit a push on the last pixel
  always_comb begin
    stage_d   = stage_q;
    pix_cnt_d = pix_cnt_q;
    push      = 1'b0;
    err_pix   = 1'b0;
    accept    = pix_valid && pix_ready_q;
    if (accept) begin
      if (pix_first) begin
        // A first pixel mid-cell abandons the partial cell and restarts at index 0
        err_pix                 = (pix_cnt_q != '0);
        stage_d[PIX_W-1:0]      = pix_data;
        pix_cnt_d               = CNT_W'(1);
      end else if (pix_cnt_q == '0) begin
        // Pixel without a cell start: dropped
        err_pix = 1'b1;
      end else begin
        stage_d[int'(pix_cnt_q) * PIX_W +: PIX_W] = pix_data;
        if (pix_cnt_q == CNT_W'(PIX_N - 1)) begin
          push      = 1'b1;
          pix_cnt_d = '0;
        end else begin
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // FIFO bookkeeping and registered head/flag outputs
  always_comb begin
    pop      = request && ready_q;
    err_req  = request && !ready_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_FW'(push) - CNT_FW'(pop);
    o_data_d = o_data_q;
    // Head changes only when it is popped or the FIFO was empty; a cell being
    // pushed this cycle is not in mem yet, so bypass it when it becomes head.
    if ((count_d != '0) && (pop || (count_q == '0))) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        o_data_d = stage_d;
      end else begin
        o_data_d = mem[rd_ptr_d];
      end
    end
    ready_d     = (count_d != '0);
    pix_ready_d = !((pix_cnt_d == CNT_W'(PIX_N - 1)) && (count_d == CNT_FW'(DEPTH)));
    err_d       = err_q | err_pix | err_req;
  end

  // Cell storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= stage_d;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_q   <= '0;
      stage_q     <= '0;
      pix_ready_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      o_data_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      pix_cnt_q   <= pix_cnt_d;
      stage_q     <= stage_d;
      pix_ready_q <= pix_ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      o_data_q    <= o_data_d;
      err_q       <= err_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign ready     = ready_q;
  assign o_data    = o_data_q;
  assign proto_err = err_q;

`ifdef FEEDER_STAT_EN
  logic [15:0] in_cnt_q, out_cnt_q;

  // Free-running cell counters; their difference tracks FIFO occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (push) in_cnt_q  <= in_cnt_q + 16'd1;
      if (pop)  out_cnt_q <= out_cnt_q + 16'd1;
    end
  end

  assign cell_in_cnt  = in_cnt_q;
  assign cell_out_cnt = out_cnt_q;
`endif

endmodule

// File: tb/tb_hog_cell_feeder.sv
// Testbench for hog_cell_feeder: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_hog_cell_feeder;

  localparam int PIX_W  = 8;
  localparam int CELL_S = 10;
  localparam int PIX_N  = CELL_S * CELL_S - 4;
  localparam int IN_W   = PIX_W * PIX_N;
  localparam int DEPTH  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pix_valid = 1'b0;
  logic             pix_first = 1'b0;
  logic [PIX_W-1:0] pix_data = '0;
  logic             request = 1'b0;
  logic             pix_ready;
  logic             ready;
  logic [IN_W-1:0]  o_data;
  logic             proto_err;
`ifdef FEEDER_STAT_EN
  logic [15:0]      cell_in_cnt;
  logic [15:0]      cell_out_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hog_cell_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .pix_first (pix_first),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .ready     (ready),
    .request   (request),
    .o_data    (o_data),
    .proto_err (proto_err)
`ifdef FEEDER_STAT_EN
    ,
    .cell_in_cnt  (cell_in_cnt),
    .cell_out_cnt (cell_out_cnt)
`endif
  );

  // ---------------- reference model ----------------
  logic [PIX_W-1:0] stg [PIX_N];
  logic [IN_W-1:0]  mq [$];
  int               m_cnt = 0;
  bit               m_err = 1'b0;
  bit               m_pix_ready = 1'b0;
  bit               m_ready = 1'b0;
  logic [IN_W-1:0]  m_odata = '0;
  int               m_in = 0;
  int               m_out = 0;

  function automatic logic [IN_W-1:0] pack_cell();
    logic [IN_W-1:0] r;
    r = '0;
    for (int k = 0; k < PIX_N; k++) r[k*PIX_W +: PIX_W] = stg[k];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; mq.delete(); m_err = 1'b0; m_pix_ready = 1'b0;
      m_ready = 1'b0; m_odata = '0; m_in = 0; m_out = 0;
    end else begin
      if (request) begin
        if (mq.size() != 0) begin
          void'(mq.pop_front());
          m_out++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (pix_valid && m_pix_ready) begin
        if (pix_first) begin
          if (m_cnt != 0) m_err = 1'b1;
          stg[0] = pix_data;
          m_cnt  = 1;
        end else if (m_cnt == 0) begin
          m_err = 1'b1;
        end else begin
          stg[m_cnt] = pix_data;
          m_cnt++;
          if (m_cnt == PIX_N) begin
            mq.push_back(pack_cell());
            m_cnt = 0;
            m_in++;
          end
        end
      end
      m_pix_ready = !(m_cnt == PIX_N - 1 && mq.size() == DEPTH);
      m_ready     = (mq.size() != 0);
      if (mq.size() != 0) m_odata = mq[0];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; pix_valid = 1'b0; pix_first = 1'b0; request = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Present one pixel and hold it until the feeder takes it
  task automatic send_pix(input logic [PIX_W-1:0] d, input bit f);
    int g;
    pix_valid = 1'b1; pix_data = d; pix_first = f;
    g = 0;
    while (pix_ready !== 1'b1 && g < 200) begin
      step();
      g++;
    end
    if (g >= 200) begin
      n_err++;
      $display("FAIL send_pix_timeout pix_ready=%b expected 1 within 200 cycles", pix_ready);
    end
    step();
  endtask

  // n pixels of a cell starting at pixel 0; sequential data k+1 or random
  task automatic send_pixels(input int n, input bit seq);
    for (int k = 0; k < n; k++)
      send_pix(seq ? PIX_W'(k + 1) : PIX_W'($urandom), k == 0);
    pix_valid = 1'b0; pix_first = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b0; request = 1'b0;
    step();
    n_vec++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_pix_ready got %b exp 0", pix_ready); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", ready); end
    n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL reset_o_data got %h exp 0", o_data); end
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
    rst = 1'b0;
    step();
    n_vec++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_pix_ready got %b exp 1", pix_ready); end
  endtask

  task automatic test_single_cell();
    logic [PIX_W-1:0] lo, hi;
    for (int k = 0; k < PIX_N - 1; k++) send_pix(PIX_W'(k + 1), k == 0);
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL single_ready_early got %b exp 0", ready); end
    send_pix(PIX_W'(PIX_N), 1'b0);
    pix_valid = 1'b0;
    lo = o_data[PIX_W-1:0];
    hi = o_data[IN_W-1 -: PIX_W];
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b exp 1", ready); end
    n_vec++; if (lo !== 8'h01) begin n_err++; $display("FAIL single_pix0 got %h exp 01", lo); end
    n_vec++; if (hi !== 8'h60) begin n_err++; $display("FAIL single_pix95 got %h exp 60", hi); end
    n_vec++; if (o_data !== m_odata) begin n_err++; $display("FAIL single_o_data got %h exp %h", o_data, m_odata); end
    request = 1'b1;
    step();
    request = 1'b0;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL single_pop_ready got %b exp 0", ready); end
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL single_proto_err got %b exp 0", proto_err); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 4; c++) send_pixels(PIX_N, 1'b0);
    for (int k = 0; k < PIX_N - 1; k++) send_pix(PIX_W'($urandom), k == 0);
    pix_valid = 1'b1; pix_first = 1'b0; pix_data = PIX_W'($urandom);
    for (int s = 0; s < 3; s++) begin
      step();
      n_vec++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL fill_stall_pix_ready got %b exp 0", pix_ready); end
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL fill_stall_ready got %b exp 1", ready); end
    end
    request = 1'b1;
    step();
    request = 1'b0;
    n_vec++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL fill_release_pix_ready got %b exp 1", pix_ready); end
    n_vec++; if (o_data !== m_odata) begin n_err++; $display("FAIL fill_after_pop got %h exp %h", o_data, m_odata); end
    step();
    pix_valid = 1'b0;
    n_vec++; if (mq.size() != DEPTH || ready !== 1'b1) begin n_err++; $display("FAIL fill_refill ready=%b model_count=%0d exp 1/4", ready, mq.size()); end
    request = 1'b1;
    for (int s = 0; s < DEPTH; s++) begin
      step();
      n_vec++; if (o_data !== m_odata) begin n_err++; $display("FAIL fill_drain got %h exp %h", o_data, m_odata); end
    end
    request = 1'b0;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL fill_drained_ready got %b exp 0", ready); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_pixels(PIX_N, 1'b0);
    send_pixels(PIX_N, 1'b0);
    for (int k = 0; k < PIX_N - 1; k++) send_pix(PIX_W'($urandom), k == 0);
    n_vec++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL simul_pix_ready got %b exp 1", pix_ready); end
    pix_valid = 1'b1; pix_first = 1'b0; pix_data = PIX_W'($urandom); request = 1'b1;
    step();
    pix_valid = 1'b0; request = 1'b0;
    n_vec++; if (o_data !== m_odata) begin n_err++; $display("FAIL simul_head got %h exp %h", o_data, m_odata); end
    request = 1'b1;
    step();
    n_vec++; if (o_data !== m_odata || ready !== 1'b1) begin n_err++; $display("FAIL simul_second ready=%b got %h exp %h", ready, o_data, m_odata); end
    step();
    request = 1'b0;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL simul_count ready=%b exp 0 after two pops", ready); end
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL simul_proto_err got %b exp 0", proto_err); end
  endtask

  task automatic test_resync();
    logic [PIX_W-1:0] lo, hi;
    do_reset();
    send_pixels(40, 1'b0);
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL resync_pre_err got %b exp 0", proto_err); end
    send_pixels(PIX_N, 1'b1);
    lo = o_data[PIX_W-1:0];
    hi = o_data[IN_W-1 -: PIX_W];
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL resync_err got %b exp 1", proto_err); end
    n_vec++; if (lo !== 8'h01 || hi !== 8'h60) begin n_err++; $display("FAIL resync_pack got %h/%h exp 01/60", lo, hi); end
    n_vec++; if (o_data !== m_odata) begin n_err++; $display("FAIL resync_o_data got %h exp %h", o_data, m_odata); end
    request = 1'b1;
    step();
    request = 1'b0;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL resync_extra_cell ready=%b exp 0", ready); end
  endtask

  task automatic test_underflow();
    do_reset();
    request = 1'b1;
    step();
    request = 1'b0;
    n_vec++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL underflow_err got %b exp 1", proto_err); end
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL underflow_ready got %b exp 0", ready); end
    send_pixels(PIX_N, 1'b1);
    n_vec++; if (o_data !== m_odata || ready !== 1'b1) begin n_err++; $display("FAIL underflow_next ready=%b got %h exp %h", ready, o_data, m_odata); end
    request = 1'b1;
    step();
    request = 1'b0;
    step();
    n_vec++; if (proto_err !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL underflow_sticky err=%b ready=%b exp 1/0", proto_err, ready); end
  endtask

  task automatic test_reset_mid();
    logic [PIX_W-1:0] lo, hi;
    do_reset();
    send_pixels(PIX_N, 1'b0);
    send_pixels(PIX_N, 1'b0);
    send_pixels(30, 1'b0);
    rst = 1'b1;
    #1;
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b exp 0", ready); end
    n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL midrst_o_data got %h exp 0", o_data); end
    n_vec++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL midrst_pix_ready got %b exp 0", pix_ready); end
`ifdef FEEDER_STAT_EN
    n_vec++; if (cell_in_cnt !== 16'd0 || cell_out_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_stats got %0d/%0d exp 0/0", cell_in_cnt, cell_out_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    step();
    send_pixels(PIX_N, 1'b1);
    lo = o_data[PIX_W-1:0];
    hi = o_data[IN_W-1 -: PIX_W];
    n_vec++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL midrst_cnt_cleared err=%b exp 0", proto_err); end
    n_vec++; if (lo !== 8'h01 || hi !== 8'h60 || ready !== 1'b1) begin n_err++; $display("FAIL midrst_pack got %h/%h ready=%b exp 01/60/1", lo, hi, ready); end
    request = 1'b1;
    step();
    request = 1'b0;
  endtask

  task automatic test_random();
    int  idx;
    bit  acc;
    bit  slow;
    do_reset();
    idx = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      slow      = ((cyc / 600) % 2) == 0;
      pix_valid = ($urandom % 4) != 0;
      pix_first = (idx == 0);
      if (cyc > 3200 && ($urandom % 64) == 0) pix_first = ~pix_first;
      pix_data  = PIX_W'($urandom);
      request   = slow ? (($urandom % 300) == 0) : (($urandom % 3) == 0);
      acc = pix_valid && (pix_ready === 1'b1);
      step();
      if (acc) begin
        if (pix_first) idx = 1;
        else if (idx != 0) idx = (idx == PIX_N - 1) ? 0 : idx + 1;
      end
      n_vec++; if (pix_ready !== m_pix_ready) begin n_err++; $display("FAIL rand_pix_ready cyc=%0d got %b exp %b", cyc, pix_ready, m_pix_ready); end
      n_vec++; if (ready !== m_ready) begin n_err++; $display("FAIL rand_ready cyc=%0d got %b exp %b", cyc, ready, m_ready); end
      n_vec++; if (o_data !== m_odata) begin n_err++; $display("FAIL rand_o_data cyc=%0d got %h exp %h", cyc, o_data, m_odata); end
      n_vec++; if (proto_err !== m_err) begin n_err++; $display("FAIL rand_proto_err cyc=%0d got %b exp %b", cyc, proto_err, m_err); end
`ifdef FEEDER_STAT_EN
      n_vec++; if (cell_in_cnt !== 16'(m_in) || cell_out_cnt !== 16'(m_out)) begin n_err++; $display("FAIL rand_stats cyc=%0d got %0d/%0d exp %0d/%0d", cyc, cell_in_cnt, cell_out_cnt, m_in, m_out); end
`endif
    end
    pix_valid = 1'b0; pix_first = 1'b0; request = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_fill();
    test_simultaneous();
    test_resync();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
